// File: rtl/led_matrix_pkg.sv
// Shared constants and scan-state encoding for the 4x4 LED matrix scanner.
package led_matrix_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = $clog2(NUM_ROWS);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;
endpackage

// File: rtl/led_pwm.sv
// Per-row brightness PWM: counter cleared in BLANK, compared against a level
// latched at each frame boundary. Only built when LED_PWM_EN is defined.
`ifdef LED_PWM_EN
module led_pwm (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic       frame_tick,
    input  logic [3:0] brightness,
    output logic       en
);
    logic [3:0] level;
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            pwm_cnt <= '0;
        end else begin
            if (frame_tick) level <= brightness;
            // Held at zero through BLANK so the first ON cycle sees count 0.
            pwm_cnt <= on ? pwm_cnt + 4'd1 : 4'd0;
        end
    end

    assign en = (pwm_cnt < level);
endmodule
`endif

// File: rtl/led_matrix_scan.sv
// 4x4 multiplexed LED matrix scanner with double-buffered frames and per-slot
// anti-ghost blanking. Define LED_PWM_EN to build brightness PWM (led_pwm).
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV  = 12000,
    parameter int BLANK_CYC = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ROWS*NUM_COLS-1:0] frame_data,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic [3:0]                   brightness,
    output logic [NUM_ROWS-1:0]          aled,
    output logic [NUM_COLS-1:0]          kled_tri,
    output logic                         frame_done
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]                      slot_cnt;
    logic [ROW_W-1:0]                   row;
    scan_state_t                        state;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]  active;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]  shadow;
    logic                               pending;
    logic                               pending_nxt;
    logic                               slot_end;
    logic                               boundary;
    logic                               take;
    logic [NUM_COLS-1:0]                col_en;

    assign slot_end = (slot_cnt == CW'(SCAN_DIV - 1));
    assign boundary = slot_end && (row == ROW_W'(NUM_ROWS - 1));
    assign take     = frame_valid && frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            row      <= '0;
            state    <= BLANK;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) row <= row + 1'b1;
            if (state == BLANK) begin
                if (slot_cnt == CW'(BLANK_CYC - 1)) state <= ON;
            end else if (slot_end) begin
                state <= BLANK;
            end
        end
    end

    // take and (boundary && pending) are exclusive: take needs frame_ready = !pending.
    always_comb begin
        pending_nxt = pending;
        if (take)                     pending_nxt = 1'b1;
        else if (boundary && pending) pending_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (take) shadow <= frame_data;
            if (boundary && pending) active <= shadow;
            pending     <= pending_nxt;
            frame_ready <= !pending_nxt;
            frame_done  <= boundary;
        end
    end

`ifdef LED_PWM_EN
    logic pwm_on;

    led_pwm u_pwm (
        .clk        (clk),
        .rst        (rst),
        .on         (state == ON),
        .frame_tick (boundary),
        .brightness (brightness),
        .en         (pwm_on)
    );

    assign col_en = {NUM_COLS{pwm_on}};
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign col_en            = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aled     <= '0;
            kled_tri <= '0;
        end else if (state == ON) begin
            aled     <= NUM_ROWS'(1) << row;
            kled_tri <= active[row] & col_en;
        end else begin
            aled     <= '0;
            kled_tri <= '0;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed, table-driven bench for led_matrix_scan with SCAN_DIV=16, BLANK_CYC=2.
module tb_led_matrix_scan;
    logic        clk;
    logic        rst;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  brightness;
    logic [3:0]  aled;
    logic [3:0]  kled_tri;
    logic        frame_done;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;
    int stray  = 0;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [15:0] data;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [3:0]  aled;
        logic [3:0]  kled;
        logic        ready;
        logic        done;
    } chk_t;

    stim_t stim[$];
    chk_t  chk[$];

    led_matrix_scan #(.SCAN_DIV(16), .BLANK_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .aled        (aled),
        .kled_tri    (kled_tri),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_s(input int c, input logic v, input logic [15:0] d);
        stim_t s;
        s.cyc = c; s.valid = v; s.data = d;
        stim.push_back(s);
    endtask

    task automatic add_c(input int c, input logic [3:0] a, input logic [3:0] k,
                         input logic r, input logic d);
        chk_t e;
        e.cyc = c; e.aled = a; e.kled = k; e.ready = r; e.done = d;
        chk.push_back(e);
    endtask

    task automatic check(input string name, input int c, input logic [3:0] a,
                         input logic [3:0] k, input logic r, input logic d);
        tests++;
        if ({aled, kled_tri, frame_ready, frame_done} !== {a, k, r, d}) begin
            fails++;
            $display("FAIL %s cyc=%0d got aled=%h kled=%h rdy=%b done=%b, exp aled=%h kled=%h rdy=%b done=%b",
                     name, c, aled, kled_tri, frame_ready, frame_done, a, k, r, d);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Called at the negedge just after rst falls; that sample point is cycle 0.
    task automatic run(input string name, input int last);
        pulses = 0;
        stray  = 0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (frame_done) begin
                pulses++;
                if ((c % 64) != 0) stray++;
            end
            foreach (chk[i])
                if (chk[i].cyc == c)
                    check(name, c, chk[i].aled, chk[i].kled, chk[i].ready, chk[i].done);
            foreach (stim[i])
                if (stim[i].cyc == c) begin
                    frame_valid = stim[i].valid;
                    frame_data  = stim[i].data;
                end
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_data  = 16'h0;
        brightness  = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_hold", -1, 4'h0, 4'h0, 1'b0, 1'b0);

        // Scan with single frame, back-to-back frames, boundary-cycle transfer.
        add_s(1,   1'b1, 16'h8421);
        add_s(2,   1'b0, 16'h0000);
        add_s(70,  1'b1, 16'hFFFF);
        add_s(71,  1'b1, 16'h0000);
        add_s(129, 1'b0, 16'h0000);
        add_s(255, 1'b1, 16'h0FF0);
        add_s(256, 1'b0, 16'h0000);

        add_c(0,   4'h0, 4'h0, 1'b0, 1'b0);
        add_c(1,   4'h0, 4'h0, 1'b1, 1'b0);
        add_c(2,   4'h0, 4'h0, 1'b0, 1'b0);
        add_c(3,   4'h1, 4'h0, 1'b0, 1'b0);
        add_c(16,  4'h1, 4'h0, 1'b0, 1'b0);
        add_c(17,  4'h0, 4'h0, 1'b0, 1'b0);
        add_c(19,  4'h2, 4'h0, 1'b0, 1'b0);
        add_c(51,  4'h8, 4'h0, 1'b0, 1'b0);
        add_c(63,  4'h8, 4'h0, 1'b0, 1'b0);
        add_c(64,  4'h8, 4'h0, 1'b1, 1'b1);
        add_c(65,  4'h0, 4'h0, 1'b1, 1'b0);
        add_c(67,  4'h1, 4'h1, 1'b1, 1'b0);
        add_c(80,  4'h1, 4'h1, 1'b0, 1'b0);
        add_c(83,  4'h2, 4'h2, 1'b0, 1'b0);
        add_c(100, 4'h4, 4'h4, 1'b0, 1'b0);
        add_c(115, 4'h8, 4'h8, 1'b0, 1'b0);
        add_c(127, 4'h8, 4'h8, 1'b0, 1'b0);
        add_c(128, 4'h8, 4'h8, 1'b1, 1'b1);
        add_c(129, 4'h0, 4'h0, 1'b0, 1'b0);
        add_c(131, 4'h1, 4'hF, 1'b0, 1'b0);
        add_c(180, 4'h8, 4'hF, 1'b0, 1'b0);
        add_c(192, 4'h8, 4'hF, 1'b1, 1'b1);
        add_c(195, 4'h1, 4'h0, 1'b1, 1'b0);
        add_c(255, 4'h8, 4'h0, 1'b1, 1'b0);
        add_c(256, 4'h8, 4'h0, 1'b0, 1'b1);
        add_c(275, 4'h2, 4'h0, 1'b0, 1'b0);
        add_c(320, 4'h8, 4'h0, 1'b1, 1'b1);
        add_c(339, 4'h2, 4'hF, 1'b1, 1'b0);
        add_c(360, 4'h4, 4'hF, 1'b1, 1'b0);

        rst = 1'b0;
        run("scan", 360);
        check_int("done_pulses", pulses, 5);
        check_int("done_stray", stray, 0);

        // Asynchronous reset in the middle of row 2 ON, no clock edge in between.
        #2 rst = 1'b1;
        #1 check("async_rst", 360, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // No frames after reset: blank columns, rows still scanning.
        stim.delete();
        chk.delete();
        add_c(0,  4'h0, 4'h0, 1'b0, 1'b0);
        add_c(1,  4'h0, 4'h0, 1'b1, 1'b0);
        add_c(3,  4'h1, 4'h0, 1'b1, 1'b0);
        add_c(35, 4'h4, 4'h0, 1'b1, 1'b0);
        add_c(51, 4'h8, 4'h0, 1'b1, 1'b0);
        add_c(64, 4'h8, 4'h0, 1'b1, 1'b1);
        add_c(67, 4'h1, 4'h0, 1'b1, 1'b0);

        rst = 1'b0;
        run("idle", 130);
        check_int("idle_pulses", pulses, 2);
        check_int("idle_stray", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_matrix_scan.md
LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 Parameter SCAN_DIV, default 12000: clk cycles per row slot (48 MHz / 12000 = 4 kHz row rate, 1 kHz frame rate); SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 48: clk cycles of all-off at the start of each row slot (anti-ghosting); SHALL be >= 1 and < SCAN_DIV.
REQ-003 clk  in  1  48 MHz internal oscillator clock; the only clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 frame_data  in  16  LED image; bit 4*r+c = LED at anode row r, cathode column c; 1 = lit.
REQ-006 frame_valid  in  1  frame_data is valid this cycle.
REQ-007 frame_ready  out  1  shadow buffer can accept a frame.
REQ-008 brightness  in  4  duty level, used only when LED_PWM_EN is defined.
REQ-009 aled  out  4  one-hot anode drive, 1 = row driven.
REQ-010 kled_tri  out  4  cathode output-enable to the SB_IO pads, 1 = column enabled.
REQ-011 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Transfer SHALL occur when frame_valid && frame_ready: shadow <= frame_data, pending <= 1; frame_ready SHALL be registered and equal !pending.
REQ-013 Scan FSM SHALL have states BLANK and ON; each row slot is BLANK for BLANK_CYC cycles, then ON for SCAN_DIV-BLANK_CYC cycles; a slot counter counts 0..SCAN_DIV-1 and wraps.
REQ-014 In BLANK, aled = 0 and kled_tri = 0.
REQ-015 In ON, aled = one-hot(row) and kled_tri = active[4*row+3 : 4*row] (gated per REQ-025 when LED_PWM_EN is defined).
REQ-016 aled and kled_tri SHALL be registered; the first ON cycle of a slot is visible one cycle after the BLANK->ON transition.
REQ-017 Row SHALL advance 0->1->2->3->0 on the last cycle of each slot.
REQ-018 Frame boundary = last cycle of the row-3 slot; frame_done SHALL pulse during the cycle that follows it.
REQ-019 At the frame boundary, if pending = 1: active <= shadow and pending <= 0, so frame_ready rises the next cycle; if pending = 0, active is held unchanged (repeat frame).
REQ-020 A transfer in the same cycle as a boundary with pending = 0 SHALL be stored in shadow and displayed from the following frame.
REQ-021 A frame is never displayed partially; active changes only at a boundary.
REQ-022 frame_data is ignored while frame_ready = 0; there is no overwrite of a pending frame.

Reset
REQ-023 While rst is high, the block SHALL hold: aled = 0, kled_tri = 0, frame_done = 0, frame_ready = 0, row = 0, state = BLANK, slot counter = 0, active = 0, shadow = 0, pending = 0.
REQ-024 frame_ready SHALL assert on the first clk edge after rst deasserts; an asynchronous reset mid-frame SHALL blank the outputs immediately, and scanning restarts at row 0 BLANK.

Configuration
REQ-025 With LED_PWM_EN defined: brightness is latched at each frame boundary; a 4-bit PWM counter, cleared on entry to ON, increments each ON cycle; kled_tri is gated off when pwm_cnt >= latched brightness (0 = dark, 15 = 15/16 duty).
REQ-026 With LED_PWM_EN undefined: brightness is ignored, no PWM logic is built, and ON is full duty.

Structure
REQ-027 Package led_matrix_pkg SHALL hold NUM_ROWS = 4, NUM_COLS = 4 and the scan-state enum {BLANK, ON}.
REQ-028 Optional sub-module led_pwm (counter + compare) SHALL be instantiated only under LED_PWM_EN; all other logic is flat.

Verification (SCAN_DIV = 16, BLANK_CYC = 2)
REQ-029 Reset release, then a single transfer of 0x8421 -> after the next boundary, rows 0..3 show kled_tri 0x1, 0x2, 0x4, 0x8 with aled 0x1, 0x2, 0x4, 0x8, each ON for 14 cycles after 2 blank cycles.
REQ-030 Two back-to-back valid frames 0xFFFF and 0x0000 -> first accepted, frame_ready low until boundary, second accepted the cycle after frame_ready rises; the display changes only at boundaries.
REQ-031 Transfer in the exact boundary cycle with pending = 0 -> shown one frame later; frame_done pulses exactly once per 64 cycles.
REQ-032 rst asserted mid-row-2 ON -> aled = kled_tri = 0 with no clk edge needed; after release, scanning restarts at row 0 and active = 0.
REQ-033 LED_PWM_EN, brightness = 4, frame 0xFFFF -> kled_tri high for 4 of every 16 ON cycles; brightness = 0 -> kled_tri always 0.
REQ-034 No frames ever sent -> outputs stay 0 while aled still scans with a period of 64 cycles.
